// File: rtl/pca_register_file_if.sv
// Write-side bus from the I2C target into the PCA9685 register store.
interface pca_register_file_if;
    logic [7:0] write_register_id_i;
    logic [7:0] write_register_value_i;
    logic       write_enable_i;

    modport master (output write_register_id_i, output write_register_value_i, output write_enable_i);
    modport slave  (input  write_register_id_i, input  write_register_value_i, input  write_enable_i);
endinterface

// File: rtl/pca_register_file.sv
// PCA9685-compatible register store: power-on defaults, MODE masking, ALL_LED broadcast,
// sleep-gated PRE_SCALE and a one-shot LED update pulse per write event.
module pca_register_file #(
    parameter logic [7:0] PRESCALE_MIN = 8'h03
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pca_register_file_if.slave  wr_if,
    output logic [0:2047]       register_blob_o,
    output logic                sleep_o,
    output logic                led_update_o
);

    // Only 00-45 and FE hold state; every other byte is hard-wired to zero.
    localparam int NUM_STORED = 70;

    logic [7:0] regs_q [NUM_STORED];
    logic [7:0] regs_d [NUM_STORED];
    logic [7:0] prescale_q, prescale_d;
    logic       en_q, en_d;
    logic       led_update_q, led_update_d;

    logic [7:0] wr_id;
    logic [7:0] wr_val;
    logic       wr_en;
    logic [1:0] all_k;
    logic [6:0] idx;
    logic       led_hit;

    always_comb begin
        wr_id        = wr_if.write_register_id_i;
        wr_val       = wr_if.write_register_value_i;
        wr_en        = wr_if.write_enable_i;
        regs_d       = regs_q;
        prescale_d   = prescale_q;
        en_d         = wr_en;
        led_update_d = 1'b0;
        idx          = '0;
        // FA..FD low bits are 2,3,0,1; adding 2 maps them to broadcast offsets 0..3.
        all_k        = wr_id[1:0] + 2'd2;
        led_hit      = ((wr_id >= 8'h06) && (wr_id <= 8'h45)) ||
                       ((wr_id >= 8'hFA) && (wr_id <= 8'hFD));

        if (wr_en) begin
            if (wr_id == 8'h00) begin
                regs_d[0] = {2'b00, wr_val[5:0]};
            end else if (wr_id == 8'h01) begin
                regs_d[1] = {3'b000, wr_val[4:0]};
            end else if (wr_id <= 8'h45) begin
                regs_d[wr_id[6:0]] = wr_val;
            end else if ((wr_id >= 8'hFA) && (wr_id <= 8'hFD)) begin
                for (int n = 0; n < 16; n++) begin
                    idx         = 7'(6 + 4 * n) + {5'd0, all_k};
                    regs_d[idx] = wr_val;
                end
            end else if ((wr_id == 8'hFE) && regs_q[0][4]) begin
                prescale_d = (wr_val < PRESCALE_MIN) ? PRESCALE_MIN : wr_val;
            end

            if (!en_q && led_hit) begin
                led_update_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_STORED; i++) begin
                regs_q[i] <= 8'h00;
            end
            for (int n = 0; n < 16; n++) begin
                regs_q[9 + 4 * n] <= 8'h10;
            end
            regs_q[0]    <= 8'h11;
            regs_q[1]    <= 8'h04;
            regs_q[2]    <= 8'hE2;
            regs_q[3]    <= 8'hE4;
            regs_q[4]    <= 8'hE8;
            regs_q[5]    <= 8'hE0;
            prescale_q   <= 8'h1E;
            en_q         <= 1'b0;
            led_update_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            prescale_q   <= prescale_d;
            en_q         <= en_d;
            led_update_q <= led_update_d;
        end
    end

    always_comb begin
        register_blob_o = '0;
        for (int i = 0; i < NUM_STORED; i++) begin
            register_blob_o[i * 8 +: 8] = regs_q[i];
        end
        register_blob_o[254 * 8 +: 8] = prescale_q;
    end

    assign sleep_o      = regs_q[0][4];
    assign led_update_o = led_update_q;

endmodule

// File: tb/tb_pca_register_file.sv
// Directed, table-driven bench for pca_register_file with hand-written multi-cycle sequences.
module tb_pca_register_file;

    logic           clk;
    logic           rst_n;
    logic [0:2047]  blob;
    logic           sleep;
    logic           led_update;
    int             checks;
    int             failures;
    int             pulses;

    pca_register_file_if bus ();

    pca_register_file dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .wr_if           (bus.slave),
        .register_blob_o (blob),
        .sleep_o         (sleep),
        .led_update_o    (led_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [7:0] val;
        logic [7:0] addr;
        logic [7:0] exp;
        logic       exp_pulse;
        logic       exp_sleep;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [7:0] blob_byte(int n);
        return blob[n * 8 +: 8];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.write_enable_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.write_register_id_i    = 8'h00;
        bus.write_register_value_i = 8'h00;
        bus.write_enable_i         = 1'b0;

        //           id     val    addr   exp    pulse sleep
        vecs[0]  = '{8'h06, 8'hAB, 8'h06, 8'hAB, 1'b1, 1'b1};
        vecs[1]  = '{8'h00, 8'hFF, 8'h00, 8'h3F, 1'b0, 1'b1};
        vecs[2]  = '{8'h01, 8'hFF, 8'h01, 8'h1F, 1'b0, 1'b1};
        vecs[3]  = '{8'h02, 8'h5C, 8'h02, 8'h5C, 1'b0, 1'b1};
        vecs[4]  = '{8'h45, 8'h77, 8'h45, 8'h77, 1'b1, 1'b1};
        vecs[5]  = '{8'h80, 8'h55, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{8'hFF, 8'h55, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{8'hFE, 8'h01, 8'hFE, 8'h03, 1'b0, 1'b1};
        vecs[8]  = '{8'hFE, 8'h20, 8'hFE, 8'h20, 1'b0, 1'b1};
        vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'hFE, 8'h40, 8'hFE, 8'h20, 1'b0, 1'b0};
        vecs[11] = '{8'h00, 8'h10, 8'h00, 8'h10, 1'b0, 1'b1};
        vecs[12] = '{8'hFE, 8'h02, 8'hFE, 8'h03, 1'b0, 1'b1};
        vecs[13] = '{8'hFE, 8'h04, 8'hFE, 8'h04, 1'b0, 1'b1};
        vecs[14] = '{8'hFA, 8'h5A, 8'hFA, 8'h00, 1'b1, 1'b1};

        // Reset defaults
        do_reset();
        #1;
        check("rst_b00", blob_byte(8'h00), 8'h11);
        check("rst_b01", blob_byte(8'h01), 8'h04);
        check("rst_b02", blob_byte(8'h02), 8'hE2);
        check("rst_b03", blob_byte(8'h03), 8'hE4);
        check("rst_b04", blob_byte(8'h04), 8'hE8);
        check("rst_b05", blob_byte(8'h05), 8'hE0);
        check("rst_b06", blob_byte(8'h06), 8'h00);
        check("rst_b09", blob_byte(8'h09), 8'h10);
        check("rst_b45", blob_byte(8'h45), 8'h10);
        check("rst_b46", blob_byte(8'h46), 8'h00);
        check("rst_bFE", blob_byte(8'hFE), 8'h1E);
        check("rst_sleep", {7'd0, sleep}, 8'h01);
        check("rst_pulse", {7'd0, led_update}, 8'h00);

        // Single-cycle write vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.write_register_id_i    = vecs[i].id;
            bus.write_register_value_i = vecs[i].val;
            bus.write_enable_i         = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_byte%02h", i, vecs[i].addr), blob_byte(int'(vecs[i].addr)), vecs[i].exp);
            check($sformatf("vec%0d_pulse", i), {7'd0, led_update}, {7'd0, vecs[i].exp_pulse});
            check($sformatf("vec%0d_sleep", i), {7'd0, sleep}, {7'd0, vecs[i].exp_sleep});
            @(negedge clk);
            bus.write_enable_i = 1'b0;
        end

        // Held enable: one pulse, immediate store
        do_reset();
        pulses = 0;
        bus.write_register_id_i    = 8'h06;
        bus.write_register_value_i = 8'hCD;
        bus.write_enable_i         = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (led_update) pulses++;
            if (c == 0) check("held_b06_first", blob_byte(8'h06), 8'hCD);
        end
        @(negedge clk);
        bus.write_enable_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (led_update) pulses++;
        end
        check("held_b06_final", blob_byte(8'h06), 8'hCD);
        check("held_pulses", 8'(pulses), 8'h01);

        // ALL_LED broadcast with one idle cycle between events
        do_reset();
        pulses = 0;
        bus.write_register_id_i    = 8'hFD;
        bus.write_register_value_i = 8'h10;
        bus.write_enable_i         = 1'b1;
        @(posedge clk); #1; if (led_update) pulses++;
        @(negedge clk); bus.write_enable_i = 1'b0;
        @(posedge clk); #1; if (led_update) pulses++;
        @(negedge clk);
        bus.write_register_id_i    = 8'hFA;
        bus.write_register_value_i = 8'h5A;
        bus.write_enable_i         = 1'b1;
        @(posedge clk); #1; if (led_update) pulses++;
        @(negedge clk); bus.write_enable_i = 1'b0;
        @(posedge clk); #1; if (led_update) pulses++;
        for (int n = 0; n < 16; n++) begin
            check($sformatf("all_on_l%0d", n), blob_byte(6 + 4 * n), 8'h5A);
            check($sformatf("all_off_h%0d", n), blob_byte(9 + 4 * n), 8'h10);
            check($sformatf("all_on_h%0d", n), blob_byte(7 + 4 * n), 8'h00);
        end
        check("all_bFA", blob_byte(8'hFA), 8'h00);
        check("all_bFD", blob_byte(8'hFD), 8'h00);
        check("all_pulses", 8'(pulses), 8'h02);

        // Reset asserted on the same edge as a write
        @(negedge clk);
        bus.write_register_id_i    = 8'h07;
        bus.write_register_value_i = 8'h33;
        bus.write_enable_i         = 1'b1;
        @(posedge clk); #1;
        check("pre_b07", blob_byte(8'h07), 8'h33);
        @(negedge clk);
        bus.write_enable_i = 1'b0;
        @(negedge clk);
        bus.write_register_value_i = 8'h99;
        bus.write_enable_i         = 1'b1;
        rst_n                      = 1'b0;
        @(posedge clk); #1;
        check("rstwr_b07", blob_byte(8'h07), 8'h00);
        check("rstwr_pulse", {7'd0, led_update}, 8'h00);
        @(posedge clk); #1;
        check("rstwr_pulse_next", {7'd0, led_update}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_b07", blob_byte(8'h07), 8'h99);
        check("post_rst_pulse", {7'd0, led_update}, 8'h01);
        @(posedge clk); #1;
        check("post_rst_pulse_once", {7'd0, led_update}, 8'h00);
        @(negedge clk);
        bus.write_enable_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
